// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer tone generator driven by note events over a valid/ready handshake.
// Pitch changes land on a falling edge; repeated notes get a silent articulation gap.
module buzzer_tone_gen #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int GAP_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [2:0] note,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing,
    output logic [2:0] cur_note
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    // Frequencies are given in centi-hertz so the rounding stays in integer math.
    function automatic logic [19:0] calc_half(input longint fc);
        longint num;
        num = longint'(CLK_HZ) * 100;
        return 20'((num + fc) / (2 * fc));
    endfunction

    localparam logic [19:0] H1 = calc_half(26163);
    localparam logic [19:0] H2 = calc_half(29366);
    localparam logic [19:0] H3 = calc_half(32963);
    localparam logic [19:0] H4 = calc_half(34923);
    localparam logic [19:0] H5 = calc_half(39200);
    localparam logic [19:0] H6 = calc_half(44000);
    localparam logic [19:0] H7 = calc_half(49388);
    localparam logic [19:0] GAP_LOAD = 20'(GAP_CYCLES - 1);

    function automatic logic [1:0] eff_oct(input logic [1:0] o);
        return (o == 2'd3) ? 2'd2 : o;
    endfunction

    function automatic logic [19:0] half_of(input logic [2:0] n, input logic [1:0] o);
        logic [19:0] b;
        unique case (n)
            3'd1:    b = H1;
            3'd2:    b = H2;
            3'd3:    b = H3;
            3'd4:    b = H4;
            3'd5:    b = H5;
            3'd6:    b = H6;
            3'd7:    b = H7;
            default: b = 20'd0;
        endcase
        unique case (o)
            2'd0:    return b << 1;
            2'd1:    return b;
            default: return b >> 1;
        endcase
    endfunction

    state_t      state;
    logic [19:0] cnt;
    logic [19:0] gap_cnt;
    logic [1:0]  cur_oct;
    logic        pend_valid;
    logic [2:0]  pend_note;
    logic [1:0]  pend_oct;

    logic        fire;
    logic        same;
    logic [19:0] new_half;
    logic [19:0] cur_half;
    logic [19:0] pend_half;

    assign note_ready = (state == IDLE) || (state == PLAY && !pend_valid);
    assign playing    = (state != IDLE);
    assign fire       = note_valid && note_ready;
    assign same       = (note == cur_note) && (eff_oct(octave) == cur_oct);
    assign new_half   = half_of(note, octave);
    assign cur_half   = half_of(cur_note, cur_oct);
    assign pend_half  = half_of(pend_note, pend_oct);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gap_cnt    <= '0;
            speaker    <= 1'b0;
            cur_note   <= '0;
            cur_oct    <= '0;
            pend_valid <= 1'b0;
            pend_note  <= '0;
            pend_oct   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (fire && note != 3'd0) begin
                        state    <= PLAY;
                        cnt      <= new_half - 20'd1;
                        cur_note <= note;
                        cur_oct  <= eff_oct(octave);
                    end
                end
                PLAY: begin
                    if (fire && note != 3'd0 && same) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                        speaker <= 1'b0;
                    end else begin
                        if (fire) begin
                            pend_valid <= 1'b1;
                            pend_note  <= note;
                            pend_oct   <= eff_oct(octave);
                        end
                        if (cnt == 20'd0) begin
                            speaker <= ~speaker;
                            // A pending event only takes over on a falling edge.
                            if (pend_valid && speaker) begin
                                pend_valid <= 1'b0;
                                if (pend_note == 3'd0) begin
                                    state    <= IDLE;
                                    cnt      <= '0;
                                    cur_note <= '0;
                                    cur_oct  <= '0;
                                end else begin
                                    cnt      <= pend_half - 20'd1;
                                    cur_note <= pend_note;
                                    cur_oct  <= pend_oct;
                                end
                            end else begin
                                cnt <= cur_half - 20'd1;
                            end
                        end else begin
                            cnt <= cnt - 20'd1;
                        end
                    end
                end
                GAP: begin
                    speaker <= 1'b0;
                    if (gap_cnt == 20'd0) begin
                        state <= PLAY;
                        cnt   <= cur_half - 20'd1;
                    end else begin
                        gap_cnt <= gap_cnt - 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at a 1 MHz clock setting to keep runs short.
// Half-periods here: note6=1136, note1 low=3822 / high=955, note5=1276, note3 high=758.
module tb_buzzer_tone_gen;

    localparam int CLK_HZ = 1_000_000;
    localparam int GAPC   = 100;
    localparam int LIMIT  = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       note_valid = 1'b0;
    logic       note_ready;
    logic [2:0] note = '0;
    logic [1:0] octave = '0;
    logic       speaker;
    logic       playing;
    logic [2:0] cur_note;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    buzzer_tone_gen #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid),
        .note_ready(note_ready), .note(note), .octave(octave),
        .speaker(speaker), .playing(playing), .cur_note(cur_note)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk);
        note_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] n, input logic [1:0] o, output int t);
        int k = 0;
        note = n;
        octave = o;
        note_valid = 1'b1;
        while (note_ready !== 1'b1 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (note_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: note_ready=%b required 1", note_ready);
        end
        @(posedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_spk(input logic lvl, output int t);
        int k = 0;
        while (speaker !== lvl && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        if (speaker !== lvl) begin
            n_vec++; n_err++;
            $display("FAIL wait_speaker: speaker=%b required %b", speaker, lvl);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        do_reset();
        n_vec++;
        if ({speaker, playing, cur_note, note_ready} !== 6'b00_000_1) begin
            n_err++;
            $display("FAIL reset_outputs: spk=%b play=%b note=%0d rdy=%b required 0 0 0 1",
                     speaker, playing, cur_note, note_ready);
        end
        repeat (1000) begin
            @(negedge clk);
            if ({speaker, playing, cur_note, note_ready} !== 6'b00_000_1) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_stable: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_tone();
        int t0, tr, tf, t;
        send(3'd6, 2'd1, t0);
        n_vec++;
        if ({playing, speaker, cur_note} !== 5'b1_0_110) begin
            n_err++;
            $display("FAIL tone_start: play=%b spk=%b note=%0d required 1 0 6",
                     playing, speaker, cur_note);
        end
        wait_spk(1'b1, tr);
        n_vec++;
        if (tr - t0 !== 1136) begin
            n_err++;
            $display("FAIL tone_first_rise: %0d required 1136", tr - t0);
        end
        wait_spk(1'b0, tf);
        n_vec++;
        if (tf - tr !== 1136) begin
            n_err++;
            $display("FAIL tone_high_phase: %0d required 1136", tf - tr);
        end
        t = tf;
        for (int i = 0; i < 3; i++) begin
            wait_spk(1'b1, t);
            if (i < 2) wait_spk(1'b0, t);
        end
        n_vec++;
        if (t - tr !== 3 * 2272) begin
            n_err++;
            $display("FAIL tone_3_periods: %0d required 6816", t - tr);
        end
    endtask

    task automatic test_rest();
        int t, tf, bad = 0;
        int tr = cyc;
        send(3'd0, 2'd0, t);
        n_vec++;
        if ({note_ready, playing} !== 2'b01) begin
            n_err++;
            $display("FAIL rest_pending: rdy=%b play=%b required 0 1", note_ready, playing);
        end
        wait_spk(1'b0, tf);
        n_vec++;
        if ({playing, cur_note, note_ready} !== 5'b0_000_1 || tf - tr !== 1136) begin
            n_err++;
            $display("FAIL rest_idle: play=%b note=%0d rdy=%b phase=%0d required 0 0 1 1136",
                     playing, cur_note, note_ready, tf - tr);
        end
        repeat (2500) begin
            @(negedge clk);
            if (speaker !== 1'b0 || playing !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rest_silent: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_switch();
        int t0, tr, t1, tf, t2, t3, rbad = 0;
        do_reset();
        send(3'd1, 2'd0, t0);
        wait_spk(1'b1, tr);
        n_vec++;
        if (tr - t0 !== 3822) begin
            n_err++;
            $display("FAIL switch_low_rise: %0d required 3822", tr - t0);
        end
        repeat (100) @(negedge clk);
        send(3'd1, 2'd2, t1);
        n_vec++;
        if (note_ready !== 1'b0) begin
            n_err++;
            $display("FAIL switch_ready_low: rdy=%b required 0", note_ready);
        end
        while (speaker === 1'b1 && cyc < tr + LIMIT) begin
            @(negedge clk);
            if (speaker === 1'b1 && note_ready !== 1'b0) rbad++;
        end
        tf = cyc;
        n_vec++;
        if (tf - tr !== 3822 || rbad !== 0 || note_ready !== 1'b1) begin
            n_err++;
            $display("FAIL switch_edge: phase=%0d rbad=%0d rdy=%b required 3822 0 1",
                     tf - tr, rbad, note_ready);
        end
        wait_spk(1'b1, t2);
        wait_spk(1'b0, t3);
        n_vec++;
        if (t2 - tf !== 955 || t3 - t2 !== 955) begin
            n_err++;
            $display("FAIL switch_new_half: low=%0d high=%0d required 955 955",
                     t2 - tf, t3 - t2);
        end
    endtask

    task automatic test_gap();
        int t0, tr, t1, t2, t3, bad = 0;
        do_reset();
        send(3'd5, 2'd1, t0);
        wait_spk(1'b1, tr);
        n_vec++;
        if (tr - t0 !== 1276) begin
            n_err++;
            $display("FAIL gap_first_rise: %0d required 1276", tr - t0);
        end
        send(3'd5, 2'd1, t1);
        if (speaker !== 1'b0 || note_ready !== 1'b0 || playing !== 1'b1) bad++;
        while (cyc < t1 + GAPC - 1) begin
            @(negedge clk);
            if (speaker !== 1'b0 || note_ready !== 1'b0 || playing !== 1'b1) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL gap_hold: %0d bad cycles required 0", bad);
        end
        @(negedge clk);
        n_vec++;
        if (note_ready !== 1'b1 || speaker !== 1'b0) begin
            n_err++;
            $display("FAIL gap_end: rdy=%b spk=%b required 1 0", note_ready, speaker);
        end
        wait_spk(1'b1, t2);
        wait_spk(1'b0, t3);
        n_vec++;
        if (t2 - t1 !== GAPC + 1276 || t3 - t2 !== 1276) begin
            n_err++;
            $display("FAIL gap_resume: rise=%0d high=%0d required 1376 1276",
                     t2 - t1, t3 - t2);
        end
    endtask

    task automatic test_octave_alias();
        int t0, tr, t1, t2;
        do_reset();
        send(3'd3, 2'd2, t0);
        wait_spk(1'b1, tr);
        send(3'd3, 2'd3, t1);
        n_vec++;
        if (note_ready !== 1'b0 || speaker !== 1'b0 || tr - t0 !== 758) begin
            n_err++;
            $display("FAIL alias_gap: rdy=%b spk=%b rise=%0d required 0 0 758",
                     note_ready, speaker, tr - t0);
        end
        wait_spk(1'b1, t2);
        n_vec++;
        if (t2 - t1 !== GAPC + 758) begin
            n_err++;
            $display("FAIL alias_resume: %0d required 858", t2 - t1);
        end
    endtask

    task automatic test_async_reset();
        int t0, tr, t1, bad = 0;
        do_reset();
        send(3'd2, 2'd1, t0);
        wait_spk(1'b1, tr);
        send(3'd4, 2'd1, t1);
        n_vec++;
        if (note_ready !== 1'b0 || speaker !== 1'b1 || tr - t0 !== 1703) begin
            n_err++;
            $display("FAIL async_setup: rdy=%b spk=%b rise=%0d required 0 1 1703",
                     note_ready, speaker, tr - t0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({speaker, playing, cur_note, note_ready} !== 6'b00_000_1) begin
            n_err++;
            $display("FAIL async_drop: spk=%b play=%b note=%0d rdy=%b required 0 0 0 1",
                     speaker, playing, cur_note, note_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4000) begin
            @(negedge clk);
            if (speaker !== 1'b0 || playing !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL async_pending_dropped: %0d bad cycles required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_rest();
        test_switch();
        test_gap();
        test_octave_alias();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
